// File: rtl/insdecode_pkg.sv
// Shared decode definitions for the barrel-threaded decode stage: opcode
// constants, instruction field positions and the decoded-instruction record.
package insdecode_pkg;

  localparam int NUM_TRD_DEF = 8;
  localparam int NUM_REG_DEF = 32;
  localparam int TRD_W       = $clog2(NUM_TRD_DEF);
  localparam int REG_W       = $clog2(NUM_REG_DEF);

  localparam logic [5:0] OP_LD       = 6'h20;
  localparam logic [5:0] OP_ST       = 6'h28;
  localparam logic [5:0] OP_CTL_BASE = 6'h30;

  localparam int OP_LSB = 26;
  localparam int RD_LSB = 21;
  localparam int RS_LSB = 16;
  localparam int RT_LSB = 11;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_CTL,
    CLS_ILL
  } op_cls_e;

  typedef struct packed {
    logic [5:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [31:0]      imm;
    logic             wr;
    logic             ld;
    logic             st;
    logic             ctl;
    logic             atom;
    logic             ill;
  } dec_t;

  function automatic op_cls_e classify(input logic [5:0] op);
    if (!op[5])                          return CLS_ALU;
    else if (op == OP_LD)                return CLS_LD;
    else if (op == OP_ST)                return CLS_ST;
    else if (op[5:4] == OP_CTL_BASE[5:4]) return CLS_CTL;
    else                                 return CLS_ILL;
  endfunction

  function automatic dec_t decode(input logic [31:0] w);
    dec_t    d;
    op_cls_e cls;
    d      = '0;
    d.op   = w[OP_LSB +: 6];
    d.rd   = w[RD_LSB +: REG_W];
    d.rs   = w[RS_LSB +: REG_W];
    d.rt   = w[RT_LSB +: REG_W];
    d.imm  = {{16{w[15]}}, w[15:0]};
    d.atom = w[0];
    cls    = classify(d.op);
    d.ld   = (cls == CLS_LD);
    d.st   = (cls == CLS_ST);
    d.ctl  = (cls == CLS_CTL);
    d.ill  = (cls == CLS_ILL);
    // Writing r0 is architecturally a no-op, so it never counts as a write.
    d.wr   = ((cls == CLS_ALU) || (cls == CLS_LD)) && (d.rd != '0);
    return d;
  endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// Per-thread pending-load scoreboard with rs/rt/rd lookup and per-thread busy.
// Build option SB_BYPASS_EN: lookups see this cycle's writeback clear.
module dec_scoreboard
  import insdecode_pkg::*;
#(
  parameter int NUM_TRD = NUM_TRD_DEF,
  parameter int NUM_REG = NUM_REG_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_set_en,
  input  logic [$clog2(NUM_TRD)-1:0] i_set_trd,
  input  logic [$clog2(NUM_REG)-1:0] i_set_rd,
  input  logic                       i_wb_en,
  input  logic [$clog2(NUM_TRD)-1:0] i_wb_trd,
  input  logic [$clog2(NUM_REG)-1:0] i_wb_rd,
  input  logic [NUM_TRD-1:0]         i_trd_clr,
  input  logic [$clog2(NUM_TRD)-1:0] i_lk_trd,
  input  logic [$clog2(NUM_REG)-1:0] i_lk_rs,
  input  logic [$clog2(NUM_REG)-1:0] i_lk_rt,
  input  logic [$clog2(NUM_REG)-1:0] i_lk_rd,
  output logic                       o_rs_pend,
  output logic                       o_rt_pend,
  output logic                       o_rd_pend,
  output logic [NUM_TRD-1:0]         o_busy
);

  logic [NUM_TRD-1:0][NUM_REG-1:0] r_sb;
  logic [NUM_TRD-1:0][NUM_REG-1:0] w_sb_nxt;
  logic [NUM_TRD-1:0][NUM_REG-1:0] w_view;

  // NOTE: every variable written in always_comb gets a full default first;
  // a path that skips the assignment would infer a latch.
  always_comb begin
    w_view = r_sb;
`ifdef SB_BYPASS_EN
    if (i_wb_en) w_view[i_wb_trd][i_wb_rd] = 1'b0;
`endif
  end

  // Applied lowest priority first so later writes win: wb clear, set, kill.
  always_comb begin
    w_sb_nxt = r_sb;
    if (i_wb_en)  w_sb_nxt[i_wb_trd][i_wb_rd]   = 1'b0;
    if (i_set_en) w_sb_nxt[i_set_trd][i_set_rd] = 1'b1;
    for (int t = 0; t < NUM_TRD; t++) begin
      if (i_trd_clr[t]) w_sb_nxt[t] = '0;
      w_sb_nxt[t][0] = 1'b0;
    end
  end

  // NOTE: this array is plain flops rather than a RAM, so it takes the async
  // reset -- stale pending bits after reset would replay forever.
  // NOTE: sequential state uses non-blocking assignment only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sb <= '0;
    else        r_sb <= w_sb_nxt;
  end

  assign o_rs_pend = w_view[i_lk_trd][i_lk_rs];
  assign o_rt_pend = w_view[i_lk_trd][i_lk_rt];
  assign o_rd_pend = w_view[i_lk_trd][i_lk_rd];

  always_comb begin
    o_busy = '0;
    for (int t = 0; t < NUM_TRD; t++) o_busy[t] = |r_sb[t];
  end

endmodule

// File: rtl/insdecode.sv
// Decode stage: field split, opcode classification, load-hazard replay and the
// ID/EX register. Build option SB_BYPASS_EN is handled in dec_scoreboard.
module insdecode
  import insdecode_pkg::*;
#(
  parameter int NUM_TRD = NUM_TRD_DEF,
  parameter int NUM_REG = NUM_REG_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                i_data,
  input  logic [31:0]                pc_dec,
  input  logic [$clog2(NUM_TRD)-1:0] trd_dec,
  input  logic                       i_miss,
  input  logic                       flushID,
  input  logic                       stall,
  input  logic [NUM_TRD-1:0]         valid_trd,
  input  logic [NUM_TRD-1:0]         trd_clr,
  input  logic                       wb_en,
  input  logic [$clog2(NUM_TRD)-1:0] wb_trd,
  input  logic [$clog2(NUM_REG)-1:0] wb_rd,
  output logic                       ex_vld,
  output logic [$clog2(NUM_TRD)-1:0] ex_trd,
  output logic [31:0]                ex_pc,
  output logic [5:0]                 ex_op,
  output logic [$clog2(NUM_REG)-1:0] ex_rd,
  output logic [$clog2(NUM_REG)-1:0] ex_rs,
  output logic [$clog2(NUM_REG)-1:0] ex_rt,
  output logic [31:0]                ex_imm,
  output logic                       ex_wr,
  output logic                       ex_ld,
  output logic                       ex_st,
  output logic                       ex_ctl,
  output logic                       ex_atom,
  output logic                       ex_ill,
  output logic                       rpl,
  output logic [$clog2(NUM_TRD)-1:0] rpl_trd,
  output logic [31:0]                rpl_pc,
  output logic [NUM_TRD-1:0]         sb_busy
);

  localparam int TW = $clog2(NUM_TRD);

  dec_t          w_dec;
  logic          w_in_vld;
  logic          w_use_rt;
  logic          w_rs_pend;
  logic          w_rt_pend;
  logic          w_rd_pend;
  logic          w_hazard;
  logic          w_issue;
  logic          w_replay;
  logic          w_sb_set;

  dec_t          r_ex;
  logic          r_ex_vld;
  logic [TW-1:0] r_ex_trd;
  logic [31:0]   r_ex_pc;
  logic          r_rpl;
  logic [TW-1:0] r_rpl_trd;
  logic [31:0]   r_rpl_pc;

  assign w_dec    = decode(i_data);
  assign w_in_vld = !i_miss && !flushID && valid_trd[trd_dec];
  assign w_use_rt = !w_dec.op[5] || w_dec.st;

  // rs is checked for every class; rt only where it is a source; rd for WAW.
  assign w_hazard = w_in_vld &&
                    (w_rs_pend || (w_use_rt && w_rt_pend) || (w_dec.wr && w_rd_pend));
  assign w_issue  = w_in_vld && !w_hazard;
  assign w_replay = w_in_vld && w_hazard;
  assign w_sb_set = w_issue && w_dec.ld && w_dec.wr && !stall;

  dec_scoreboard #(
    .NUM_TRD (NUM_TRD),
    .NUM_REG (NUM_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_en  (w_sb_set),
    .i_set_trd (trd_dec),
    .i_set_rd  (w_dec.rd),
    .i_wb_en   (wb_en),
    .i_wb_trd  (wb_trd),
    .i_wb_rd   (wb_rd),
    .i_trd_clr (trd_clr),
    .i_lk_trd  (trd_dec),
    .i_lk_rs   (w_dec.rs),
    .i_lk_rt   (w_dec.rt),
    .i_lk_rd   (w_dec.rd),
    .o_rs_pend (w_rs_pend),
    .o_rt_pend (w_rt_pend),
    .o_rd_pend (w_rd_pend),
    .o_busy    (sb_busy)
  );

  // Payload fields only load on issue; on a bubble they hold, which saves
  // toggling and matches the don't-care contract with EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex      <= '0;
      r_ex_vld  <= 1'b0;
      r_ex_trd  <= '0;
      r_ex_pc   <= '0;
      r_rpl     <= 1'b0;
      r_rpl_trd <= '0;
      r_rpl_pc  <= '0;
    end else if (stall) begin
      r_rpl <= 1'b0;
    end else begin
      r_ex_vld <= w_issue;
      r_rpl    <= w_replay;
      if (w_issue) begin
        r_ex     <= w_dec;
        r_ex_trd <= trd_dec;
        r_ex_pc  <= pc_dec;
      end
      if (w_replay) begin
        r_rpl_trd <= trd_dec;
        r_rpl_pc  <= pc_dec;
      end
    end
  end

  assign ex_vld  = r_ex_vld;
  assign ex_trd  = r_ex_trd;
  assign ex_pc   = r_ex_pc;
  assign ex_op   = r_ex.op;
  assign ex_rd   = r_ex.rd;
  assign ex_rs   = r_ex.rs;
  assign ex_rt   = r_ex.rt;
  assign ex_imm  = r_ex.imm;
  assign ex_wr   = r_ex.wr;
  assign ex_ld   = r_ex.ld;
  assign ex_st   = r_ex.st;
  assign ex_ctl  = r_ex.ctl;
  assign ex_atom = r_ex.atom;
  assign ex_ill  = r_ex.ill;
  assign rpl     = r_rpl;
  assign rpl_trd = r_rpl_trd;
  assign rpl_pc  = r_rpl_pc;

endmodule

// File: tb/tb_insdecode.sv
// Directed self-checking bench for insdecode; expected values are hand-derived
// from the instruction encodings. Honours SB_BYPASS_EN when defined.
module tb_insdecode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_data;
  logic [31:0] pc_dec;
  logic [2:0]  trd_dec;
  logic        i_miss;
  logic        flushID;
  logic        stall;
  logic [7:0]  valid_trd;
  logic [7:0]  trd_clr;
  logic        wb_en;
  logic [2:0]  wb_trd;
  logic [4:0]  wb_rd;
  logic        ex_vld;
  logic [2:0]  ex_trd;
  logic [31:0] ex_pc;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rd, ex_rs, ex_rt;
  logic [31:0] ex_imm;
  logic        ex_wr, ex_ld, ex_st, ex_ctl, ex_atom, ex_ill;
  logic        rpl;
  logic [2:0]  rpl_trd;
  logic [31:0] rpl_pc;
  logic [7:0]  sb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  insdecode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data    (i_data),
    .pc_dec    (pc_dec),
    .trd_dec   (trd_dec),
    .i_miss    (i_miss),
    .flushID   (flushID),
    .stall     (stall),
    .valid_trd (valid_trd),
    .trd_clr   (trd_clr),
    .wb_en     (wb_en),
    .wb_trd    (wb_trd),
    .wb_rd     (wb_rd),
    .ex_vld    (ex_vld),
    .ex_trd    (ex_trd),
    .ex_pc     (ex_pc),
    .ex_op     (ex_op),
    .ex_rd     (ex_rd),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_imm    (ex_imm),
    .ex_wr     (ex_wr),
    .ex_ld     (ex_ld),
    .ex_st     (ex_st),
    .ex_ctl    (ex_ctl),
    .ex_atom   (ex_atom),
    .ex_ill    (ex_ill),
    .rpl       (rpl),
    .rpl_trd   (rpl_trd),
    .rpl_pc    (rpl_pc),
    .sb_busy   (sb_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [15:0] lo);
    return {op, rd, rs, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] trd, input logic [31:0] pc, input logic [31:0] ins);
    trd_dec = trd;
    pc_dec  = pc;
    i_data  = ins;
    i_miss  = 1'b0;
  endtask

  task automatic wb(input logic en, input logic [2:0] trd, input logic [4:0] rd);
    wb_en  = en;
    wb_trd = trd;
    wb_rd  = rd;
  endtask

  initial begin
    logic [31:0] add_r1_r7;
    add_r1_r7 = mk(6'h00, 5'd1, 5'd7, 16'h0000);

    rst_n = 1'b0; i_data = '0; pc_dec = '0; trd_dec = '0; i_miss = 1'b1;
    flushID = 1'b0; stall = 1'b0; valid_trd = 8'hFF; trd_clr = '0;
    wb(1'b0, 3'd0, 5'd0);
    #12;
    check("por_ex_vld", 32'(ex_vld), 32'd0);
    check("por_sb_busy", 32'(sb_busy), 32'd0);
    rst_n = 1'b1;

    // Thread 3 LD r5, then reset while r5 is pending.
    drive(3'd3, 32'h10, mk(6'h20, 5'd5, 5'd0, 16'h0000));
    tick();
    check("ld_t3_vld", 32'(ex_vld), 32'd1);
    check("ld_t3_ld", 32'(ex_ld), 32'd1);
    check("ld_t3_rd", 32'(ex_rd), 32'd5);
    check("ld_t3_trd", 32'(ex_trd), 32'd3);
    check("ld_t3_busy", 32'(sb_busy), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ex_vld", 32'(ex_vld), 32'd0);
    check("rst_rpl", 32'(rpl), 32'd0);
    check("rst_sb_busy", 32'(sb_busy), 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    i_miss = 1'b1;
    rst_n  = 1'b1;
    tick();
    check("post_rst_busy", 32'(sb_busy), 32'd0);

    // Thread 2 LD r7 then dependent ADD replays; same ADD on thread 4 issues.
    drive(3'd2, 32'h100, 32'h80E0_0000);
    tick();
    check("ld_t2_vld", 32'(ex_vld), 32'd1);
    check("ld_t2_busy", 32'(sb_busy), 32'h04);
    drive(3'd2, 32'h104, add_r1_r7);
    tick();
    check("raw_rpl", 32'(rpl), 32'd1);
    check("raw_rpl_trd", 32'(rpl_trd), 32'd2);
    check("raw_rpl_pc", rpl_pc, 32'h104);
    check("raw_ex_vld", 32'(ex_vld), 32'd0);
    drive(3'd4, 32'h200, add_r1_r7);
    tick();
    check("t4_ex_vld", 32'(ex_vld), 32'd1);
    check("t4_ex_trd", 32'(ex_trd), 32'd4);
    check("t4_ex_rs", 32'(ex_rs), 32'd7);
    check("t4_ex_wr", 32'(ex_wr), 32'd1);
    check("t4_rpl", 32'(rpl), 32'd0);

    // ADD re-enters decode in the writeback cycle of r7.
    drive(3'd2, 32'h104, add_r1_r7);
    wb(1'b1, 3'd2, 5'd7);
    tick();
    wb(1'b0, 3'd0, 5'd0);
`ifdef SB_BYPASS_EN
    check("byp_ex_vld", 32'(ex_vld), 32'd1);
    check("byp_rpl", 32'(rpl), 32'd0);
`else
    check("nobyp_rpl", 32'(rpl), 32'd1);
    check("nobyp_ex_vld", 32'(ex_vld), 32'd0);
    tick();
    check("nobyp2_ex_vld", 32'(ex_vld), 32'd1);
    check("nobyp2_rpl", 32'(rpl), 32'd0);
`endif
    check("wb_ex_pc", ex_pc, 32'h104);
    check("wb_busy", 32'(sb_busy), 32'd0);

    // Stall for 3 cycles with a hazarding ADD in decode; wb clears mid-stall.
    drive(3'd1, 32'h300, mk(6'h20, 5'd9, 5'd0, 16'h0000));
    tick();
    check("ld_t1_busy", 32'(sb_busy), 32'h02);
    drive(3'd1, 32'h304, mk(6'h00, 5'd2, 5'd9, 16'h0000));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb(i == 1, 3'd1, 5'd9);
      tick();
      check("stall_ex_pc", ex_pc, 32'h300);
      check("stall_ex_vld", 32'(ex_vld), 32'd1);
      check("stall_rpl", 32'(rpl), 32'd0);
    end
    wb(1'b0, 3'd0, 5'd0);
    check("stall_wb_busy", 32'(sb_busy), 32'd0);
    stall = 1'b0;
    tick();
    check("unstall_ex_vld", 32'(ex_vld), 32'd1);
    check("unstall_ex_pc", ex_pc, 32'h304);
    check("unstall_rpl", 32'(rpl), 32'd0);

    // LD r0 never writes; LD with same-cycle kill leaves nothing pending.
    drive(3'd0, 32'h400, mk(6'h20, 5'd0, 5'd0, 16'h0000));
    tick();
    check("ld_r0_vld", 32'(ex_vld), 32'd1);
    check("ld_r0_wr", 32'(ex_wr), 32'd0);
    check("ld_r0_busy", 32'(sb_busy), 32'd0);
    drive(3'd1, 32'h404, mk(6'h20, 5'd9, 5'd0, 16'h0000));
    trd_clr = 8'h02;
    tick();
    trd_clr = 8'h00;
    check("kill_ex_vld", 32'(ex_vld), 32'd1);
    check("kill_busy", 32'(sb_busy), 32'd0);

    // Set beats a same-cycle wb clear of the same bit; stray wb is harmless.
    drive(3'd1, 32'h408, mk(6'h20, 5'd9, 5'd0, 16'h0000));
    wb(1'b1, 3'd1, 5'd9);
    tick();
    check("set_vs_clr_busy", 32'(sb_busy), 32'h02);
    i_miss = 1'b1;
    tick();
    check("wb_clr_busy", 32'(sb_busy), 32'd0);
    tick();
    wb(1'b0, 3'd0, 5'd0);
    check("stray_wb_busy", 32'(sb_busy), 32'd0);
    check("stray_wb_rpl", 32'(rpl), 32'd0);

    // rt hazards for ALU and ST on thread 5.
    drive(3'd5, 32'h500, mk(6'h20, 5'd5, 5'd0, 16'h0000));
    tick();
    check("ld_t5_busy", 32'(sb_busy), 32'h20);
    drive(3'd5, 32'h504, mk(6'h00, 5'd1, 5'd0, {5'd5, 11'd0}));
    tick();
    check("alu_rt_rpl", 32'(rpl), 32'd1);
    check("alu_rt_pc", rpl_pc, 32'h504);
    drive(3'd5, 32'h508, mk(6'h28, 5'd0, 5'd0, {5'd5, 11'd0}));
    tick();
    check("st_rt_rpl", 32'(rpl), 32'd1);
    check("st_rt_pc", rpl_pc, 32'h508);

    // Squash sources: flushID, i_miss, invalid thread -- hazarding ADD on t5.
    for (int c = 0; c < 3; c++) begin
      drive(3'd0, 32'h600, mk(6'h00, 5'd3, 5'd4, 16'h0000));
      tick();
      check("pre_squash_vld", 32'(ex_vld), 32'd1);
      drive(3'd5, 32'h50C, mk(6'h00, 5'd1, 5'd5, 16'h0000));
      flushID   = (c == 0);
      i_miss    = (c == 1);
      valid_trd = (c == 2) ? 8'hDF : 8'hFF;
      tick();
      check("squash_ex_vld", 32'(ex_vld), 32'd0);
      check("squash_rpl", 32'(rpl), 32'd0);
      flushID   = 1'b0;
      valid_trd = 8'hFF;
    end

    // Class decode: illegal, control with atom, store.
    drive(3'd0, 32'h700, mk(6'h25, 5'd3, 5'd0, 16'h8001));
    tick();
    check("ill_ex_vld", 32'(ex_vld), 32'd1);
    check("ill_ex_ill", 32'(ex_ill), 32'd1);
    check("ill_ex_wr", 32'(ex_wr), 32'd0);
    check("ill_ex_op", 32'(ex_op), 32'h25);
    check("ill_ex_imm", ex_imm, 32'hFFFF_8001);
    drive(3'd0, 32'h704, mk(6'h3C, 5'd0, 5'd0, 16'h0001));
    tick();
    check("ctl_ex_ctl", 32'(ex_ctl), 32'd1);
    check("ctl_ex_atom", 32'(ex_atom), 32'd1);
    check("ctl_ex_ill", 32'(ex_ill), 32'd0);
    drive(3'd0, 32'h708, mk(6'h28, 5'd4, 5'd6, {5'd7, 11'h7FF}));
    tick();
    check("st_ex_st", 32'(ex_st), 32'd1);
    check("st_ex_wr", 32'(ex_wr), 32'd0);
    check("st_ex_rt", 32'(ex_rt), 32'd7);
    check("st_ex_imm", ex_imm, 32'h0000_3FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
